// File: rtl/icache_ctrl_if.sv
// Bundles the fetch-side, memory-side and counter signals of icache_ctrl.
// slave is the cache's view; master is the CPU and memory side.
interface icache_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = 16
);
   logic                    req_valid_i;
   logic [ADDR_WIDTH-1:0]   req_addr_i;
   logic                    resp_valid_o;
   logic [31:0]             resp_instr_o;
   logic                    busy_o;
   logic                    flush_i;
   logic                    mem_rd_req_valid_o;
   logic                    mem_req_is_instr_o;
   logic [ADDR_WIDTH-1:0]   mem_req_address_o;
   logic                    mem_data_valid_i;
   logic [LINE_BYTES*8-1:0] mem_data_i;
   logic [31:0]             hit_count_o;
   logic [31:0]             miss_count_o;

   modport slave (
      input  req_valid_i, req_addr_i, flush_i, mem_data_valid_i, mem_data_i,
      output resp_valid_o, resp_instr_o, busy_o, mem_rd_req_valid_o,
             mem_req_is_instr_o, mem_req_address_o, hit_count_o, miss_count_o
   );

   modport master (
      output req_valid_i, req_addr_i, flush_i, mem_data_valid_i, mem_data_i,
      input  resp_valid_o, resp_instr_o, busy_o, mem_rd_req_valid_o,
             mem_req_is_instr_o, mem_req_address_o, hit_count_o, miss_count_o
   );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with whole-cache flush and
// hit/miss counters. One outstanding line fill at a time.
//
// state | meaning
// IDLE  | serving hits, accepting requests, applying flushes
// MISS  | line-read outstanding, waiting for mem_data_valid_i
module icache_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 4
) (
   input logic         clk,
   input logic         rst,
   icache_ctrl_if.slave bus
);
   localparam int OFF   = $clog2(LINE_BYTES);
   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG   = ADDR_WIDTH - OFF - IDX;
   localparam int LW    = LINE_BYTES * 8;
   localparam int WORDS = LINE_BYTES / 4;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                state_q, state_d;
   logic [NUM_LINES-1:0]  valid_q;
   logic [TAG-1:0]        tag_q  [NUM_LINES];
   logic [LW-1:0]         data_q [NUM_LINES];
   logic                  flush_pend_q;
   logic [ADDR_WIDTH-1:0] miss_addr_q;

   logic                  resp_valid_q;
   logic [31:0]           resp_instr_q;
   logic                  mem_req_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           hit_cnt_q;
   logic [31:0]           miss_cnt_q;

   logic                  accept_hit, accept_miss, fill, clear_all, set_pend;

   logic [TAG-1:0]        req_tag;
   logic [IDX-1:0]        req_idx;
   logic [TAG-1:0]        miss_tag;
   logic [IDX-1:0]        miss_idx;
   logic                  hit;

   assign req_tag  = bus.req_addr_i[ADDR_WIDTH-1:OFF+IDX];
   assign req_idx  = bus.req_addr_i[OFF+IDX-1:OFF];
   assign miss_tag = miss_addr_q[ADDR_WIDTH-1:OFF+IDX];
   assign miss_idx = miss_addr_q[OFF+IDX-1:OFF];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // Shift-based select keeps the word field usable even for 4-byte lines.
   function automatic logic [31:0] sel_word(input logic [LW-1:0] line,
                                            input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] w;
      logic [LW-1:0]         shifted;
      w       = (addr >> 2) & ADDR_WIDTH'(WORDS - 1);
      shifted = line >> (w << 5);
      return shifted[31:0];
   endfunction

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d     = state_q;
      accept_hit  = 1'b0;
      accept_miss = 1'b0;
      fill        = 1'b0;
      clear_all   = 1'b0;
      set_pend    = 1'b0;
      case (state_q)
         IDLE: begin
            // A deferred or fresh flush takes the cycle; any request is refused.
            if (flush_pend_q || bus.flush_i) begin
               clear_all = 1'b1;
            end else if (bus.req_valid_i) begin
               if (hit) begin
                  accept_hit = 1'b1;
               end else begin
                  accept_miss = 1'b1;
                  state_d     = MISS;
               end
            end
         end
         MISS: begin
            if (bus.flush_i) set_pend = 1'b1;
            if (bus.mem_data_valid_i) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, valid bits and pending-flush flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (fill)           valid_q[miss_idx] <= 1'b1;
         if (clear_all)      valid_q           <= '0;
         if (set_pend)       flush_pend_q      <= 1'b1;
         else if (clear_all) flush_pend_q      <= 1'b0;
      end
   end

   // Tag and data arrays; contents are qualified by valid_q so no reset needed.
   always_ff @(posedge clk) begin
      if (rst && fill) begin
         tag_q[miss_idx]  <= miss_tag;
         data_q[miss_idx] <= bus.mem_data_i;
      end
   end

   // Miss bookkeeping and memory request outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         miss_addr_q <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
      end else if (accept_miss) begin
         miss_addr_q <= bus.req_addr_i;
         mem_req_q   <= 1'b1;
         mem_addr_q  <= {bus.req_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
      end else if (fill) begin
         mem_req_q   <= 1'b0;
      end
   end

   // Response register and performance counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_valid_q <= 1'b0;
         resp_instr_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         resp_valid_q <= accept_hit | fill;
         if (accept_hit) resp_instr_q <= sel_word(data_q[req_idx], bus.req_addr_i);
         if (fill)       resp_instr_q <= sel_word(bus.mem_data_i, miss_addr_q);
         if (accept_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (accept_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign bus.resp_valid_o       = resp_valid_q;
   assign bus.resp_instr_o       = resp_instr_q;
   assign bus.busy_o             = mem_req_q;
   assign bus.mem_rd_req_valid_o = mem_req_q;
   assign bus.mem_req_is_instr_o = mem_req_q;
   assign bus.mem_req_address_o  = mem_addr_q;
   assign bus.hit_count_o        = hit_cnt_q;
   assign bus.miss_count_o       = miss_cnt_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: driver predicts responses from a simple
// cache/memory model and queues them; a negedge monitor checks the DUT output.
module tb_icache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;

   icache_ctrl_if #(.ADDR_WIDTH(32), .LINE_BYTES(16)) bus ();

   icache_ctrl #(.ADDR_WIDTH(32), .LINE_BYTES(16), .NUM_LINES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] instr;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: 4 lines of 16 bytes, indexed by plain address arithmetic.
   bit          m_valid [4];
   int unsigned m_tag   [4];
   logic [31:0] m_data  [4][4];
   int          m_hits   = 0;
   int          m_misses = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h93 + 32'h80 * ((a >> 2) & 32'h3) + (((a & ~32'hF) ^ 32'h1000) << 8);
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word(la + 32'(4 * w));
      return l;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a / 16) % 4);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / 64);
   endfunction

   task automatic m_fill(input logic [31:0] a);
      int i;
      i = m_idx(a);
      m_valid[i] = 1'b1;
      m_tag[i]   = a / 64;
      for (int w = 0; w < 4; w++) m_data[i][w] = mem_word((a & ~32'hF) + 32'(4 * w));
   endtask

   task automatic m_inval();
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_hit_count"},  64'(bus.hit_count_o),  64'(m_hits));
      chk({tag, "_miss_count"}, 64'(bus.miss_count_o), 64'(m_misses));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response pulse must match the oldest expectation, on time.
   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual=%08h required=none (t=%0t)",
                     bus.resp_instr_o, $time);
         end else begin
            e = exp_q.pop_front();
            chk("resp_instr", 64'(bus.resp_instr_o), 64'(e.instr));
            chk("resp_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   // Issue one fetch while the cache is idle and play the memory side if it misses.
   task automatic fetch(input logic [31:0] a, input int dly, input bit fl, input bit stall);
      exp_t e;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = a;
      if (m_hit(a)) begin
         e.instr = m_data[m_idx(a)][(a / 4) % 4];
         e.due   = cyc + 1;
         exp_q.push_back(e);
         tick();
         bus.req_valid_i = 1'b0;
         m_hits++;
         chk_cnt("hit");
         chk("hit_no_memreq", 64'(bus.mem_rd_req_valid_o), 64'd0);
      end else begin
         tick();
         bus.req_valid_i = 1'b0;
         m_misses++;
         chk_cnt("miss_accept");
         chk("miss_busy",     64'(bus.busy_o),             64'd1);
         chk("miss_memreq",   64'(bus.mem_rd_req_valid_o), 64'd1);
         chk("miss_is_instr", 64'(bus.mem_req_is_instr_o), 64'd1);
         chk("miss_address",  64'(bus.mem_req_address_o),  64'(a & ~32'hF));
         for (int i = 0; i < dly; i++) begin
            if (fl && i == 0) bus.flush_i = 1'b1;
            if (stall) begin
               bus.req_valid_i = 1'b1;
               bus.req_addr_i  = $urandom;
            end
            tick();
            bus.flush_i = 1'b0;
         end
         bus.req_valid_i      = 1'b0;
         bus.mem_data_valid_i = 1'b1;
         bus.mem_data_i       = mem_line(a & ~32'hF);
         if (fl && dly == 0) bus.flush_i = 1'b1;
         e.instr = mem_word(a);
         e.due   = cyc + 1;
         exp_q.push_back(e);
         tick();
         bus.mem_data_valid_i = 1'b0;
         bus.flush_i          = 1'b0;
         m_fill(a);
         if (fl) m_inval();
         chk("fill_busy_drop",   64'(bus.busy_o),             64'd0);
         chk("fill_memreq_drop", 64'(bus.mem_rd_req_valid_o), 64'd0);
         chk_cnt("fill");
         if (fl) begin
            // The first idle cycle after a fill with a pending flush refuses requests.
            bus.req_valid_i = 1'b1;
            bus.req_addr_i  = a;
            tick();
            bus.req_valid_i = 1'b0;
            chk_cnt("pend_flush");
            chk("pend_flush_busy", 64'(bus.busy_o), 64'd0);
         end
      end
   endtask

   task automatic idle_flush(input bit with_req, input logic [31:0] a);
      bus.flush_i     = 1'b1;
      bus.req_valid_i = with_req;
      bus.req_addr_i  = a;
      tick();
      bus.flush_i     = 1'b0;
      bus.req_valid_i = 1'b0;
      m_inval();
      chk_cnt("idle_flush");
      chk("idle_flush_busy", 64'(bus.busy_o), 64'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid_o),       64'd0);
      chk({tag, "_resp_instr"}, 64'(bus.resp_instr_o),       64'd0);
      chk({tag, "_busy"},       64'(bus.busy_o),             64'd0);
      chk({tag, "_memreq"},     64'(bus.mem_rd_req_valid_o), 64'd0);
      chk({tag, "_is_instr"},   64'(bus.mem_req_is_instr_o), 64'd0);
      chk({tag, "_mem_addr"},   64'(bus.mem_req_address_o),  64'd0);
      chk({tag, "_hit_count"},  64'(bus.hit_count_o),        64'd0);
      chk({tag, "_miss_count"}, 64'(bus.miss_count_o),       64'd0);
   endtask

   logic [31:0] bases [4] = '{32'h1000, 32'h1040, 32'h2000, 32'h3F80};

   initial begin
      logic [31:0] a;
      bus.req_valid_i      = 1'b0;
      bus.req_addr_i       = '0;
      bus.flush_i          = 1'b0;
      bus.mem_data_valid_i = 1'b0;
      bus.mem_data_i       = '0;
      m_inval();

      repeat (3) tick();
      chk_reset_vals("reset");
      rst = 1'b1;
      tick();

      // Cold miss, then back-to-back hits in the same line.
      fetch(32'h1000, 3, 1'b0, 1'b0);
      fetch(32'h1004, 0, 1'b0, 1'b0);
      fetch(32'h1008, 0, 1'b0, 1'b0);

      // Conflicting lines on index 0.
      fetch(32'h1040, 1, 1'b0, 1'b0);
      fetch(32'h1000, 2, 1'b0, 1'b0);
      fetch(32'h1040, 0, 1'b0, 1'b0);

      // Flush in IDLE with a simultaneous fetch, then the line misses again.
      idle_flush(1'b1, 32'h1000);
      fetch(32'h1000, 1, 1'b0, 1'b0);
      fetch(32'h100C, 0, 1'b0, 1'b0);

      // Flush during a miss; the same line must miss afterwards.
      fetch(32'h1080, 2, 1'b1, 1'b0);
      fetch(32'h1084, 0, 1'b0, 1'b0);

      // Requests during a miss are ignored.
      fetch(32'h2000, 3, 1'b0, 1'b1);

      // Reset in the middle of a miss, followed by a late data beat.
      idle_flush(1'b0, 32'h0);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h2040;
      tick();
      bus.req_valid_i = 1'b0;
      m_misses++;
      chk("rst_miss_memreq", 64'(bus.mem_rd_req_valid_o), 64'd1);
      tick();
      rst = 1'b0;
      tick();
      m_hits   = 0;
      m_misses = 0;
      m_inval();
      chk_reset_vals("midmiss_reset");
      rst = 1'b1;
      bus.mem_data_valid_i = 1'b1;
      bus.mem_data_i       = ~mem_line(32'h2040);
      tick();
      bus.mem_data_valid_i = 1'b0;
      chk("late_data_resp", 64'(bus.resp_valid_o), 64'd0);
      chk("late_data_busy", 64'(bus.busy_o),       64'd0);
      fetch(32'h2040, 1, 1'b0, 1'b0);
      fetch(32'h2048, 0, 1'b0, 1'b0);

      // Randomised traffic over a few conflicting regions.
      for (int n = 0; n < 300; n++) begin
         a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15) * 4)
             + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 5)
            idle_flush(1'($urandom_range(0, 1)), a);
         else
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) tick();
      end

      repeat (4) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache that sits between the CPU fetch stage and the shared line-wide memory model. It serves 32-bit instruction fetches from locally held lines. On a miss it issues a single line-read request to memory, fills the line, and returns the requested word. It also provides a whole-cache flush and hit/miss performance counters.

## Interface
- `ADDR_WIDTH`, default 32: width of fetch and memory addresses.
- `LINE_BYTES`, default 16: bytes per line. Power of two, ≥ 4.
- `NUM_LINES`, default 4: number of lines. Power of two, ≥ 2.
- Derived values:
  - `OFF = log2(LINE_BYTES)`
  - `IDX = log2(NUM_LINES)`
  - `TAG = ADDR_WIDTH - OFF - IDX`

Ports (name, direction, width, meaning):
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `req_valid_i`  in  1  fetch request. Accepted only in a cycle where `busy_o` = 0.
- `req_addr_i`  in  ADDR_WIDTH  fetch address. Word-aligned; bits [1:0] are ignored.
- `resp_valid_o`  out  1  one-cycle pulse that accompanies a valid `resp_instr_o`.
- `resp_instr_o`  out  32  fetched instruction.
- `busy_o`  out  1  high while a miss is outstanding.
- `flush_i`  in  1  invalidate all lines.
- `mem_rd_req_valid_o`  out  1  line-read request. Level signal, held until data returns.
- `mem_req_is_instr_o`  out  1  equals `mem_rd_req_valid_o`.
- `mem_req_address_o`  out  ADDR_WIDTH  line-aligned miss address: low OFF bits are 0.
- `mem_data_valid_i`  in  1  memory line data valid. One-cycle pulse.
- `mem_data_i`  in  LINE_BYTES*8  line data. Little-endian: byte b is at bits [8b+7:8b].
- `hit_count_o`  out  32  number of accepted requests that hit. Wraps modulo 2^32.
- `miss_count_o`  out  32  number of accepted requests that missed. Wraps modulo 2^32.

## Operation
- Address split:
  - tag = addr[ADDR_WIDTH-1 : OFF+IDX]
  - index = addr[OFF+IDX-1 : OFF]
  - word = addr[OFF-1 : 2]
- Selected instruction = line[32*word+31 : 32*word].
- Storage per line: valid bit, TAG-bit tag, LINE_BYTES*8-bit data.
- The state machine has two states, IDLE and MISS.
- In IDLE, with `req_valid_i` = 1 and `flush_i` = 0, the request is accepted:
  - Hit (line valid and tag matches): register the word, pulse `resp_valid_o` next cycle, increment `hit_count_o`, stay in IDLE.
  - Miss: latch the address, increment `miss_count_o`, go to MISS.
- In MISS:
  - `mem_rd_req_valid_o` = 1 and `busy_o` = 1.
  - `mem_req_address_o` = latched address with low OFF bits cleared.
  - `req_valid_i` is ignored.
  - On `mem_data_valid_i` = 1: write data, tag and valid=1 into the indexed line, register the requested word from `mem_data_i`, pulse `resp_valid_o` next cycle, return to IDLE.
- `mem_data_valid_i` arriving in IDLE is ignored; no state change.
- Flush in IDLE: clear all valid bits at the edge. A `req_valid_i` in the same cycle is NOT accepted, and no counter changes.
- Flush in MISS:
  - Set a pending flag.
  - The fill completes and the response is delivered normally.
  - All valid bits, including the just-filled line, are cleared on the cycle after the fill, i.e. the first IDLE cycle.
  - A request in that cycle is not accepted.
- Reset (`rst` = 0 at an edge), including mid-miss:
  - State → IDLE; all valid bits cleared; pending flush cleared.
  - Counters → 0.
  - Any outstanding request is dropped with no response.
  - A late `mem_data_valid_i` after reset is ignored.

## Timing
- Reset values:
  - `resp_valid_o` = 0, `resp_instr_o` = 0, `busy_o` = 0
  - `mem_rd_req_valid_o` = 0, `mem_req_is_instr_o` = 0, `mem_req_address_o` = 0
  - `hit_count_o` = 0, `miss_count_o` = 0
- All outputs are registered.
- Hit: request accepted at edge N → `resp_valid_o` = 1 during cycle N+1. A new request can be accepted in cycle N+1, giving one fetch per cycle back-to-back.
- Miss: request accepted at edge N → `mem_rd_req_valid_o` and `busy_o` high from cycle N+1.
  - If `mem_data_valid_i` is sampled at edge M, then request and busy drop in cycle M+1 and `resp_valid_o` = 1 in cycle M+1.
  - Minimum miss latency, with data in the first MISS cycle: 2 cycles from acceptance to response.
- `resp_instr_o` holds its last value when `resp_valid_o` = 0.
- Counters update at the same edge that accepts the request.

## Test plan
- Cold miss:
  - Stimulus: fetch 0x1000; memory returns line 0x…_00000113_00000093 after 3 cycles.
  - Required response: one request at address 0x1000; `resp_instr_o` = 0x00000093 one cycle after data; `miss_count_o` = 1.
- Hit:
  - Stimulus: fetch 0x1004 and 0x1008 back-to-back after the cold miss.
  - Required response: `resp_valid_o` on consecutive cycles with 0x00000113 and word 2; no memory request; `hit_count_o` = 2.
- Conflict:
  - Stimulus: fetch 0x1000, then 0x1040 (same index with default parameters), then 0x1000.
  - Required response: three misses, each with its own memory request, and correct data each time.
- Flush:
  - Stimulus: flush in IDLE with a simultaneous fetch of 0x1000.
  - Required response: request not accepted, counters unchanged, next fetch of 0x1000 misses.
  - Stimulus: flush during MISS.
  - Required response: response still delivered; a subsequent fetch of the same line misses.
- Reset mid-miss:
  - Stimulus: drop `rst` to 0 while `mem_rd_req_valid_o` = 1, then send a late `mem_data_valid_i`.
  - Required response: all outputs return to their reset values; no `resp_valid_o`; the late data does not fill any line.
- Stall:
  - Stimulus: assert `req_valid_i` with a different address during MISS.
  - Required response: ignored; only the original miss is served; `miss_count_o` increments once.
